wb_stage_regfile: RTL and testbench

//  Write-back end of the MEM->WB pipeline register: consumes the registered W-stage controls and data,

---
 rtl/wb_stage_regfile_pkg.sv | 12 +
 rtl/wb_stage_regfile_if.sv | 24 ++
 rtl/wb_stage_regfile_bank.sv | 39 +++
 rtl/wb_stage_regfile.sv | 96 +++++++++
 tb/tb_wb_stage_regfile.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_regfile_pkg.sv
// Shared constants for the write-back stage and its register file.
// Register index width, the PC index and the write counter width.
package wb_stage_regfile_pkg;

    localparam int unsigned D_WIDTH   = 32;
    localparam int unsigned NUM_GPR   = 15;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned CNT_W     = 16;

    localparam logic [REG_IDX_W-1:0] REG_PC = 4'hF;

endpackage

// File: rtl/wb_stage_regfile_if.sv
// W-stage control/data bundle leaving the MEM->WB pipeline register.
// The master drives it; the write-back stage consumes it as slave.
interface wb_stage_regfile_if
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DW = D_WIDTH
);

    logic                 PCSrcW;
    logic                 RegWriteW;
    logic                 MemtoRegW;
    logic [DW-1:0]        ReadDataW;
    logic [DW-1:0]        ALUOutW;
    logic [REG_IDX_W-1:0] WA3W;

    modport master (
        output PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W
    );

    modport slave (
        input PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W
    );

endinterface

// File: rtl/wb_stage_regfile_bank.sv
// NREG x DW flop array: one synchronous write port, two asynchronous read ports, no bypass.
// Indices beyond the stored range read as zero and ignore writes.
module regfile_bank
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DW   = D_WIDTH,
    parameter int unsigned NREG = NUM_GPR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [DW-1:0]        wdata_i,
    input  logic [REG_IDX_W-1:0] raddr1_i,
    input  logic [REG_IDX_W-1:0] raddr2_i,
    output logic [DW-1:0]        rdata1_o,
    output logic [DW-1:0]        rdata2_o
);

    localparam logic [REG_IDX_W-1:0] LastIdx = REG_IDX_W'(NREG - 1);

    logic [DW-1:0] rf_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i <= LastIdx)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i <= LastIdx) ? rf_q[raddr1_i] : '0;
        rdata2_o = (raddr2_i <= LastIdx) ? rf_q[raddr2_i] : '0;
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: result select, GPR commit with same-cycle read bypass,
// R15 redirect flops and a saturating committed-write counter.
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DW   = D_WIDTH,
    parameter int unsigned NREG = NUM_GPR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_stage_regfile_if.slave    w_if,
    input  logic [REG_IDX_W-1:0] i_RA1D,
    input  logic [REG_IDX_W-1:0] i_RA2D,
    input  logic [DW-1:0]        i_PCPlus8D,
    output logic [DW-1:0]        o_RD1D,
    output logic [DW-1:0]        o_RD2D,
    output logic [DW-1:0]        o_ResultW,
    output logic                 o_PCRedirW,
    output logic [DW-1:0]        o_PCTargetW,
    output logic [CNT_W-1:0]     o_WrCnt
);

    logic [DW-1:0]    result;
    logic             gpr_we;
    logic [DW-1:0]    bank_rd1;
    logic [DW-1:0]    bank_rd2;
    logic             redir_q, redir_d;
    logic [DW-1:0]    target_q, target_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        result = w_if.MemtoRegW ? w_if.ReadDataW : w_if.ALUOutW;
        gpr_we = w_if.RegWriteW && (w_if.WA3W != REG_PC);
    end

    regfile_bank #(
        .DW   (DW),
        .NREG (NREG)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (gpr_we),
        .waddr_i  (w_if.WA3W),
        .wdata_i  (result),
        .raddr1_i (i_RA1D),
        .raddr2_i (i_RA2D),
        .rdata1_o (bank_rd1),
        .rdata2_o (bank_rd2)
    );

    // R15 reads the fetch PC; otherwise a same-cycle commit to the address wins over the array.
    always_comb begin
        if (i_RA1D == REG_PC) begin
            o_RD1D = i_PCPlus8D;
        end else if (gpr_we && (w_if.WA3W == i_RA1D)) begin
            o_RD1D = result;
        end else begin
            o_RD1D = bank_rd1;
        end

        if (i_RA2D == REG_PC) begin
            o_RD2D = i_PCPlus8D;
        end else if (gpr_we && (w_if.WA3W == i_RA2D)) begin
            o_RD2D = result;
        end else begin
            o_RD2D = bank_rd2;
        end
    end

    always_comb begin
        redir_d  = w_if.PCSrcW;
        target_d = w_if.PCSrcW ? result : target_q;
        wr_cnt_d = wr_cnt_q;
        if (gpr_we && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_q  <= 1'b0;
            target_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            redir_q  <= redir_d;
            target_q <= target_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign o_ResultW   = result;
    assign o_PCRedirW  = redir_q;
    assign o_PCTargetW = target_q;
    assign o_WrCnt     = wr_cnt_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile: directed cases, random traffic against an
// array-based model, asynchronous reset mid-stream and counter saturation.
module tb_wb_stage_regfile;
    import wb_stage_regfile_pkg::*;

    localparam int unsigned DW = D_WIDTH;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    ra1, ra2;
    logic [DW-1:0] pcp8;
    logic [DW-1:0] rd1, rd2, res, tgt;
    logic          redir;
    logic [15:0]   cnt;

    int checks   = 0;
    int failures = 0;

    wb_stage_regfile_if #(.DW(DW)) w_if ();

    wb_stage_regfile #(
        .DW   (DW),
        .NREG (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_if        (w_if.slave),
        .i_RA1D      (ra1),
        .i_RA2D      (ra2),
        .i_PCPlus8D  (pcp8),
        .o_RD1D      (rd1),
        .o_RD2D      (rd2),
        .o_ResultW   (res),
        .o_PCRedirW  (redir),
        .o_PCTargetW (tgt),
        .o_WrCnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model state: architectural registers and outputs as seen after the most recent edge.
    logic [DW-1:0] m_gpr [15];
    logic [15:0]   m_cnt;
    logic          m_redir;
    logic [DW-1:0] m_tgt;

    function automatic logic [DW-1:0] m_result();
        return w_if.MemtoRegW ? w_if.ReadDataW : w_if.ALUOutW;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [3:0] ra);
        if (ra == 4'd15) return pcp8;
        if (w_if.RegWriteW && w_if.WA3W == ra) return m_result();
        return m_gpr[ra];
    endfunction

    // Compare at negedge, then advance the model for the inputs held until the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 15; i++) m_gpr[i] = '0;
                m_cnt   = '0;
                m_redir = 1'b0;
                m_tgt   = '0;
            end else begin
                chk("m_result", res, m_result());
                chk("m_rd1", rd1, m_read(ra1));
                chk("m_rd2", rd2, m_read(ra2));
                chk("m_redir", {31'd0, redir}, {31'd0, m_redir});
                chk("m_target", tgt, m_tgt);
                chk("m_wrcnt", {16'd0, cnt}, {16'd0, m_cnt});
                if (w_if.RegWriteW && w_if.WA3W != 4'd15) begin
                    m_gpr[w_if.WA3W] = m_result();
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                m_redir = w_if.PCSrcW;
                if (w_if.PCSrcW) m_tgt = m_result();
            end
        end
    end

    task automatic drive(input logic pcsrc, input logic regwr, input logic m2r,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2);
        @(posedge clk);
        #1;
        w_if.PCSrcW    = pcsrc;
        w_if.RegWriteW = regwr;
        w_if.MemtoRegW = m2r;
        w_if.ReadDataW = rdata;
        w_if.ALUOutW   = alu;
        w_if.WA3W      = wa;
        ra1            = r1;
        ra2            = r2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        w_if.PCSrcW    = 1'b0;
        w_if.RegWriteW = 1'b0;
        w_if.MemtoRegW = 1'b0;
        w_if.ReadDataW = '0;
        w_if.ALUOutW   = '0;
        w_if.WA3W      = '0;
        ra1  = '0;
        ra2  = '0;
        pcp8 = 32'h2008;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_redir", {31'd0, redir}, 32'd0);
        chk("rst_wrcnt", {16'd0, cnt}, 32'd0);
        chk("rst_target", tgt, 32'd0);
        rst_n = 1'b1;

        // ALU write with bypass, then read back from the array
        drive(0, 1, 0, 32'h0, 32'h1234, 4'd3, 4'd3, 4'd0);
        settle();
        chk("alu_bypass", rd1, 32'h1234);
        chk("alu_result", res, 32'h1234);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd3, 4'd3, 4'd0);
        settle();
        chk("alu_array", rd1, 32'h1234);

        // Load write to R14
        drive(0, 1, 1, 32'hDEAD_BEEF, 32'h5, 4'd14, 4'd0, 4'd0);
        settle();
        chk("load_result", res, 32'hDEAD_BEEF);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd3, 4'd14);
        settle();
        chk("load_array", rd2, 32'hDEAD_BEEF);
        chk("load_wrcnt", {16'd0, cnt}, 32'd2);

        // Branch to R15: redirect only, array and counter untouched
        drive(1, 1, 0, 32'h0, 32'h100, 4'd15, 4'd0, 4'd0);
        settle();
        chk("br_redir_pre", {31'd0, redir}, 32'd0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd15, 4'd14);
        settle();
        chk("br_redir", {31'd0, redir}, 32'd1);
        chk("br_target", tgt, 32'h100);
        chk("br_rd_pc", rd1, 32'h2008);
        chk("br_r14_kept", rd2, 32'hDEAD_BEEF);
        chk("br_wrcnt", {16'd0, cnt}, 32'd2);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
        settle();
        chk("br_pulse_end", {31'd0, redir}, 32'd0);
        chk("br_target_hold", tgt, 32'h100);

        // No write: R5 keeps reset value
        drive(0, 0, 0, 32'h0, 32'hFFFF, 4'd5, 4'd5, 4'd5);
        settle();
        chk("nowr_nobypass", rd1, 32'h0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd5, 4'd0);
        settle();
        chk("nowr_array", rd1, 32'h0);
        chk("nowr_wrcnt", {16'd0, cnt}, 32'd2);

        // Redirect together with a GPR commit
        drive(1, 1, 0, 32'h0, 32'h77, 4'd7, 4'd7, 4'd7);
        settle();
        chk("both_bypass", rd2, 32'h77);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd7, 4'd0);
        settle();
        chk("both_redir", {31'd0, redir}, 32'd1);
        chk("both_target", tgt, 32'h77);
        chk("both_array", rd1, 32'h77);
        chk("both_wrcnt", {16'd0, cnt}, 32'd3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic pc, rw;
            logic [3:0] wa;
            pc = ($urandom_range(0, 7) == 0);
            rw = $urandom_range(0, 1) == 1;
            wa = 4'($urandom_range(0, 15));
            pcp8 = $urandom;
            if (!pc && !rw && $urandom_range(0, 9) == 0) wa = 4'bx;
            drive(pc, rw, $urandom_range(0, 1) == 1, $urandom, $urandom, wa,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-stream, checked between clock edges
        @(posedge clk);
        #2;
        w_if.PCSrcW    = 1'b0;
        w_if.RegWriteW = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_redir", {31'd0, redir}, 32'd0);
        chk("arst_wrcnt", {16'd0, cnt}, 32'd0);
        chk("arst_target", tgt, 32'd0);
        for (int i = 0; i < 15; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(14 - i);
            #1;
            chk("arst_rd1", rd1, 32'd0);
            chk("arst_rd2", rd2, 32'd0);
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Saturation: write until the counter reaches FFFE, then three more
        n = 0;
        while (m_cnt != 16'hFFFE && n < 70000) begin
            drive(0, 1, 0, 32'h0, $urandom, 4'($urandom_range(0, 14)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            settle();
            n++;
        end
        if (n >= 70000) begin
            checks++;
            failures++;
            $display("FAIL sat_timeout: counter did not approach 16'hFFFE within budget");
        end
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
        settle();
        chk("sat_fffe", {16'd0, cnt}, 32'h0000_FFFE);
        repeat (3) drive(0, 1, 0, 32'h0, 32'hA5, 4'd1, 4'd0, 4'd0);
        drive(0, 0, 0, 32'h0, 32'h0, 4'd0, 4'd1, 4'd0);
        settle();
        chk("sat_ffff", {16'd0, cnt}, 32'h0000_FFFF);
        chk("sat_r1", rd1, 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
